// File: rtl/cam_4bit_word_pkg.sv
// Shared types and constants for the 4-bit CAM word and its bit cells.
package cam4_pkg;

  localparam int CAM_WIDTH = 4;

  typedef logic [CAM_WIDTH-1:0] cam_word_t;

  localparam cam_word_t CAM_RST_WORD = '0;

endpackage

// File: rtl/cam_4bit_word_if.sv
// Write/read/search signal bundle for one CAM word.
// The array side drives through "master"; the storage row uses "slave".
interface cam_4bit_word_if
  import cam4_pkg::*;
#(
  parameter int WIDTH = CAM_WIDTH
);

  logic             wlwr;
  logic [WIDTH-1:0] dl;
  logic [WIDTH-1:0] dlb;
  logic             rwl;
  logic [WIDTH-1:0] rbl;
  logic [WIDTH-1:0] camdata;
  logic             mismatch;
  logic             match;

  modport master (
    output wlwr, dl, dlb, rwl, camdata,
    input  rbl, mismatch, match
  );

  modport slave (
    input  wlwr, dl, dlb, rwl, camdata,
    output rbl, mismatch, match
  );

endinterface

// File: rtl/cam_4bit_word_bit_cell.sv
// One CAM bit cell: differentially qualified write, XOR compare against
// the search key, and an optional registered read port.
// Optional feature macro: CAM4_READ_PORT_EN (read flop built when defined).
module cam_bit_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic wlwr,
  input  logic dl,
  input  logic dlb,
  input  logic rwl,
  input  logic camdata,
  output logic rbl,
  output logic mismatch
);

  logic q;

  // Store the bit only when the data pair is differential; 00/11 leave the cell undriven.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (wlwr && (dl != dlb)) begin
      q <= dl;
    end
  end

  assign mismatch = q ^ camdata;

`ifdef CAM4_READ_PORT_EN
  // Read flop samples the pre-write value, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rbl <= RST_VAL;
    end else if (rwl) begin
      rbl <= q;
    end
  end
`else
  logic unused_rwl;
  assign unused_rwl = rwl;
  assign rbl        = 1'b0;
`endif

endmodule

// File: rtl/cam_4bit_word.sv
// Single CAM storage word: WIDTH bit cells whose per-bit mismatches are
// OR-reduced into the word mismatch/match result.
// Optional feature macro: CAM4_READ_PORT_EN (registered rbl read port).
module cam_4bit_word
  import cam4_pkg::*;
#(
  parameter int WIDTH = CAM_WIDTH
) (
  input logic          clk,
  input logic          rst,
  cam_4bit_word_if.slave bus
);

  logic [WIDTH-1:0] bit_mismatch;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    cam_bit_cell #(
      .RST_VAL (CAM_RST_WORD[i])
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .wlwr     (bus.wlwr),
      .dl       (bus.dl[i]),
      .dlb      (bus.dlb[i]),
      .rwl      (bus.rwl),
      .camdata  (bus.camdata[i]),
      .rbl      (bus.rbl[i]),
      .mismatch (bit_mismatch[i])
    );
  end

  assign bus.mismatch = |bit_mismatch;
  assign bus.match    = ~bus.mismatch;

endmodule

// File: tb/tb_cam_4bit_word.sv
// Self-checking bench for cam_4bit_word: directed vector table followed by
// randomized cycles checked against a word-level reference model.
module tb_cam_4bit_word;

`ifdef CAM4_READ_PORT_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  cam_4bit_word_if #(.WIDTH(4)) bus ();

  cam_4bit_word #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_failed = 0;

  // Reference model state.
  logic [3:0] q_m;
  logic [3:0] rbl_m;

  typedef struct {
    logic       rst;
    logic       wlwr;
    logic [3:0] dl;
    logic [3:0] dlb;
    logic       rwl;
    logic [3:0] cam;
    logic       chk_pre;
    logic       pre_match;
    logic       post_match;
    logic [3:0] post_rbl;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic wl, input logic [3:0] d,
                       input logic [3:0] db, input logic rw, input logic [3:0] c);
    rst         = r;
    bus.wlwr    = wl;
    bus.dl      = d;
    bus.dlb     = db;
    bus.rwl     = rw;
    bus.camdata = c;
  endtask

  // Word-level model of one clock edge.
  function automatic void model_edge(input logic r, input logic wl, input logic [3:0] d,
                                     input logic [3:0] db, input logic rw);
    logic [3:0] nq;
    if (r) begin
      q_m   = 4'h0;
      rbl_m = 4'h0;
    end else begin
      nq = q_m;
      if (wl) begin
        for (int b = 0; b < 4; b++)
          if (d[b] != db[b]) nq[b] = d[b];
      end
      if (rw && READ_EN) rbl_m = q_m;
      q_m = nq;
    end
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_rbl;
    logic [3:0] r_dl, r_dlb, r_cam;
    logic       r_rst, r_wl, r_rw;

    q_m   = 4'h0;
    rbl_m = 4'h0;
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);

    //            rst   wl    dl    dlb   rwl   cam   chk   pre   post  rbl
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0};
    vecs[1]  = '{1'b0, 1'b1, 4'hA, 4'h5, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1, 4'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[3]  = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 4'hA};
    // dl=0,dlb=3: bits 1:0 are differential and clear, bits 3:2 hold -> 4'h8
    vecs[4]  = '{1'b0, 1'b1, 4'h0, 4'h3, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 4'hA};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h8, 1'b1, 1'b1, 1'b1, 4'h8};
    vecs[6]  = '{1'b0, 1'b1, 4'h6, 4'h9, 1'b0, 4'h6, 1'b1, 1'b0, 1'b1, 4'h8};
    vecs[7]  = '{1'b0, 1'b1, 4'h9, 4'h6, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 4'h6};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h9, 1'b1, 1'b1, 1'b1, 4'h6};
    vecs[9]  = '{1'b0, 1'b1, 4'hC, 4'h3, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1, 4'h9};
    vecs[10] = '{1'b1, 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0};
    vecs[11] = '{1'b0, 1'b1, 4'h5, 4'hA, 1'b0, 4'h5, 1'b1, 1'b0, 1'b1, 4'h0};
    vecs[12] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 4'h5};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].wlwr, vecs[i].dl, vecs[i].dlb, vecs[i].rwl, vecs[i].cam);
      #1;
      if (vecs[i].chk_pre) begin
        check($sformatf("vec%0d pre match", i), {3'b0, bus.match}, {3'b0, vecs[i].pre_match});
        check($sformatf("vec%0d pre mismatch", i), {3'b0, bus.mismatch}, {3'b0, ~vecs[i].pre_match});
      end
      @(posedge clk);
      model_edge(vecs[i].rst, vecs[i].wlwr, vecs[i].dl, vecs[i].dlb, vecs[i].rwl);
      #1;
      exp_rbl = READ_EN ? vecs[i].post_rbl : 4'h0;
      check($sformatf("vec%0d post match", i), {3'b0, bus.match}, {3'b0, vecs[i].post_match});
      check($sformatf("vec%0d post mismatch", i), {3'b0, bus.mismatch}, {3'b0, ~vecs[i].post_match});
      check($sformatf("vec%0d rbl", i), bus.rbl, exp_rbl);
    end

    // Randomized cycles against the reference model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      r_rst = ($urandom_range(0, 19) == 0);
      r_wl  = $urandom_range(0, 1) == 1;
      r_rw  = $urandom_range(0, 1) == 1;
      r_dl  = 4'($urandom_range(0, 15));
      r_dlb = 4'($urandom_range(0, 15));
      r_cam = ($urandom_range(0, 2) == 0) ? q_m : 4'($urandom_range(0, 15));
      drive(r_rst, r_wl, r_dl, r_dlb, r_rw, r_cam);
      #1;
      check("rand pre match", {3'b0, bus.match}, {3'b0, (q_m == r_cam)});
      check("rand pre mismatch", {3'b0, bus.mismatch}, {3'b0, (q_m != r_cam)});
      @(posedge clk);
      model_edge(r_rst, r_wl, r_dl, r_dlb, r_rw);
      #1;
      check("rand post match", {3'b0, bus.match}, {3'b0, (q_m == r_cam)});
      check("rand rbl", bus.rbl, rbl_m);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
